// File: rtl/mips_io_pkg.sv
// Shared constants for the memory-mapped MIPS I/O blocks: register map,
// CTRL field positions and the hex seven-segment lookup table.
package mips_io_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLANK_LSB = 8;
    localparam int CTRL_BLANK_MSB = 15;
    localparam int CTRL_DP_LSB    = 16;
    localparam int CTRL_DP_MSB    = 23;

    // Only enable, blank mask and dp mask are storable; all other bits read 0.
    localparam logic [31:0] CTRL_RW_MASK = 32'h00FF_FF01;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by nibble value.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder (active-high segments,
// bit 0 = segment a).
module hex_to_seg7
    import mips_io_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble value has an entry so no default is needed.
    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/mips_gpo_display.sv
// Memory-mapped 32-bit output register with double-buffered, frame-aligned
// commit and an 8-digit multiplexed seven-segment scanner.
module mips_gpo_display
    import mips_io_pkg::*;
#(
    parameter int REFRESH_DIV = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        sel,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] gpo,
    output logic [7:0]  LEDSEL,
    output logic [7:0]  LEDOUT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      gpo_q, gpo_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       ledsel_q, ledsel_d;
    logic [7:0]       ledout_q, ledout_d;

    logic             enable_s;
    logic             wrap_s;
    logic             commit_s;
    logic             wr_s;
    logic [7:0]       blank_s;
    logic [7:0]       dp_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;

    assign enable_s = ctrl_q[CTRL_EN_BIT];
    assign blank_s  = ctrl_q[CTRL_BLANK_MSB:CTRL_BLANK_LSB];
    assign dp_s     = ctrl_q[CTRL_DP_MSB:CTRL_DP_LSB];
    assign wr_s     = sel & we;
    assign nibble_s = gpo_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Next-state: bus writes, frame-aligned commit, refresh divider and scan outputs.
    always_comb begin
        shadow_d  = shadow_q;
        gpo_d     = gpo_q;
        ctrl_d    = ctrl_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;

        wrap_s = enable_s && (cnt_q == CNT_LAST);
        // With scanning off there is no frame to tear, so commit right away.
        commit_s = enable_s ? (wrap_s && (idx_q == 3'd7)) : 1'b1;

        if (commit_s && pending_q) begin
            gpo_d     = shadow_q;
            pending_d = 1'b0;
        end else begin
            gpo_d     = gpo_q;
            pending_d = pending_q;
        end

        // A write on the commit edge lands after the commit has taken the old shadow.
        if (wr_s) begin
            case (a)
                ADDR_DATA: begin
                    shadow_d  = wd;
                    pending_d = 1'b1;
                end
                ADDR_CTRL: ctrl_d = wd & CTRL_RW_MASK;
                default:   ctrl_d = ctrl_q;
            endcase
        end else begin
            shadow_d = shadow_q;
        end

        if (!enable_s) begin
            cnt_d = '0;
            idx_d = 3'd0;
        end else if (wrap_s) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end

        if (!enable_s || blank_s[idx_q]) begin
            ledsel_d = 8'hFF;
        end else begin
            ledsel_d = ~(8'h01 << idx_q);
        end

        if (enable_s) begin
            ledout_d = ~{dp_s[idx_q], seg_s};
        end else begin
            ledout_d = 8'hFF;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= 32'h0000_0000;
            gpo_q     <= 32'h0000_0000;
            ctrl_q    <= 32'h0000_0000;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            ledsel_q  <= 8'hFF;
            ledout_q  <= 8'hFF;
        end else begin
            shadow_q  <= shadow_d;
            gpo_q     <= gpo_d;
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ledsel_q  <= ledsel_d;
            ledout_q  <= ledout_d;
        end
    end

    // Combinational read-back mux.
    always_comb begin
        case (a)
            ADDR_DATA:   rd = gpo_q;
            ADDR_CTRL:   rd = ctrl_q;
            ADDR_STATUS: rd = {31'b0, pending_q};
            default:     rd = 32'h0000_0000;
        endcase
    end

    assign gpo    = gpo_q;
    assign LEDSEL = ledsel_q;
    assign LEDOUT = ledout_q;

endmodule

// File: doc/mips_gpo_display.md
Name: mips_gpo_display

Overview:
- Memory-mapped general-purpose output and 8-digit seven-segment display driver for the single-cycle MIPS system.
- It is the output-direction counterpart to the gpi1 input path. The processor stores a 32-bit word, and the block shows it as 8 hex digits on LEDSEL/LEDOUT using time-multiplexed scanning.
- New data is double-buffered and committed only at a frame boundary, so a frame never mixes old and new digits.
- Software reads back committed data, control and status over the same bus.

Parameters:
- REFRESH_DIV, 16: clock cycles each digit is held active; legal range is ≥ 2.
- CNT_W, 16: width of the refresh divider counter; requires REFRESH_DIV ≤ 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  bus write strobe, qualified by sel.
- sel  in  1  block select from the address decoder.
- a  in  2  word address: 0=DATA, 1=CTRL, 2=STATUS, 3=reserved.
- wd  in  32  write data.
- rd  out  32  combinational read data.
- gpo  out  32  committed data word; also a raw general-purpose output.
- LEDSEL  out  8  digit enables, active-low, one-hot-zero.
- LEDOUT  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (reset=0, asynchronous) sets these values:
  - shadow=0, gpo=0, ctrl=0 (display disabled), pending=0.
  - Divider count=0, digit index=0.
  - LEDSEL=8'hFF, LEDOUT=8'hFF.
- Write DATA (sel&we, a=0): shadow<=wd and pending<=1 on the same edge.
  - A second write while pending overwrites shadow; pending stays 1 and no data is queued.
- Write CTRL (a=1): the write takes effect immediately.
  - ctrl[0] = enable.
  - ctrl[15:8] = blank mask; bit i=1 forces digit i dark.
  - ctrl[23:16] = decimal-point mask.
  - Other bits read as 0.
- Writes to a=2 and a=3 are ignored.
- Read data:
  - a=0 returns gpo.
  - a=1 returns ctrl.
  - a=2 returns {31'b0, pending}.
  - a=3 returns 0.
- Divider:
  - When enable=1, count increments every cycle; on REFRESH_DIV-1 it wraps to 0 and digit index advances modulo 8 (7→0).
  - When enable=0, count and index hold at 0 and LEDSEL=8'hFF.
- Commit:
  - Condition: at the edge where count wraps and index goes 7→0, if pending=1 then gpo<=shadow and pending<=0.
  - When enable=0, pending commits on the next clock edge, with no frame to tear.
  - If a DATA write and a commit edge coincide, the commit takes the old shadow, the new value lands in shadow, and pending stays 1.
- Display outputs, registered, so they lag the index by one cycle:
  - LEDSEL = ~(1<<index), unless the digit is blanked or enable=0, in which case LEDSEL=8'hFF.
  - LEDOUT = ~{dpmask[index], seg7(gpo[4*index+3 -: 4])}.
  - Digit 0 displays gpo[3:0].
- seg7 encoding is standard hex 0-F (a=bit0): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Reset asserted mid-frame returns every register to its reset value immediately; a pending write is lost.
- Frame period = 8*REFRESH_DIV cycles.

Decomposition:
- Shared package mips_io_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_CTRL=1, ADDR_STATUS=2.
  - CTRL field bit positions.
  - The 16-entry seg7 constant table.
- One natural sub-module, hex_to_seg7: a combinational 4-bit nibble to 7-bit segment decoder.
- The top level contains the bus registers, commit logic, divider and scan registers.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release.
  - Required response: LEDSEL=FF, LEDOUT=FF, gpo=0, rd at a=2 is 0; all values stay put for 20 cycles with enable=0.
- Basic scan: write CTRL=1, then DATA=32'h76543210, with REFRESH_DIV=4.
  - Required response: gpo=76543210 after the first frame boundary.
  - Each digit i is held 4 cycles with LEDSEL=~(1<<i); LEDOUT is 8'hC0 for digit 0 and 8'hF9 for digit 1.
- No tearing: mid-frame (index=3), write DATA=32'hFFFFFFFF.
  - Required response: STATUS=1 and digits 3-7 still show the old value.
  - gpo changes only at the 7→0 wrap; STATUS then reads 0.
- Collision: issue a DATA write on exactly the commit edge.
  - Required response: gpo gets the previous shadow, STATUS=1, and the new value commits one frame later.
- Blank/dp: write CTRL=32'h00010201.
  - Required response: digit 1 always shows LEDSEL=FF; digit 0 shows LEDOUT with bit7=0.
- Reset mid-operation: assert reset while pending=1 and index=5.
  - Required response: outputs go to reset values asynchronously (before the next clk edge) and the pending data is never committed.
